// File: rtl/frame_flusher_pkg.sv
// rtl/frame_flusher_pkg.sv - shared widths, screen size and scan states for the frame flusher
package frame_flusher_pkg;

    localparam int COLOUR_W = 6;
    localparam int COORD_W  = 8;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } flush_state_t;

endpackage

// File: rtl/layer_priority_mux.sv
// rtl/layer_priority_mux.sv - picks the colour of the lowest-index enabled layer, else background
module layer_priority_mux
    import frame_flusher_pkg::*;
#(
    parameter int                    N_LAYERS  = 4,
    parameter logic [COLOUR_W-1:0]   BG_COLOUR = '0
) (
    input  logic [COLOUR_W*N_LAYERS-1:0] layer_colour,
    input  logic [N_LAYERS-1:0]          layer_enable,
    output logic [COLOUR_W-1:0]          colour
);

    // Walk from the highest index down so the lowest enabled index is the last to write.
    always_comb begin
        colour = BG_COLOUR;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (layer_enable[i]) begin
                colour = layer_colour[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

endmodule

// File: rtl/frame_flusher.sv
// rtl/frame_flusher.sv - raster-scans the framebuffer, resolves layer priority, issues one plot per cycle
module frame_flusher
    import frame_flusher_pkg::*;
#(
    parameter int                  WIDTH     = SCREEN_W,
    parameter int                  HEIGHT    = SCREEN_H,
    parameter int                  N_LAYERS  = 4,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [COLOUR_W*N_LAYERS-1:0] layer_colour,
    input  logic [N_LAYERS-1:0]          layer_enable,
    output logic [COORD_W-1:0]           flush_x,
    output logic [COORD_W-1:0]           flush_y,
    output logic [COORD_W-1:0]           vga_x,
    output logic [COORD_W-1:0]           vga_y,
    output logic [COLOUR_W-1:0]          vga_colour,
    output logic                         vga_plot,
    output logic                         busy,
    output logic                         done,
    output logic [7:0]                   frame_count
);

    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(HEIGHT - 1);

    flush_state_t        state;
    logic [COLOUR_W-1:0] selected_colour;

    layer_priority_mux #(
        .N_LAYERS  (N_LAYERS),
        .BG_COLOUR (BG_COLOUR)
    ) u_priority (
        .layer_colour (layer_colour),
        .layer_enable (layer_enable),
        .colour       (selected_colour)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            flush_x     <= '0;
            flush_y     <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    flush_x  <= '0;
                    flush_y  <= '0;
                    vga_plot <= 1'b0;
                    done     <= 1'b0;
                    // Start is honoured in the done cycle too, so a held start chains frames.
                    if (start) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                SCAN: begin
                    vga_x      <= flush_x;
                    vga_y      <= flush_y;
                    vga_colour <= selected_colour;
                    vga_plot   <= 1'b1;
                    if (flush_x == LAST_X && flush_y == LAST_Y) begin
                        flush_x <= '0;
                        flush_y <= '0;
                        state   <= FINISH;
                    end else if (flush_x == LAST_X) begin
                        flush_x <= '0;
                        flush_y <= flush_y + 1'b1;
                    end else begin
                        flush_x <= flush_x + 1'b1;
                    end
                end
                FINISH: begin
                    vga_plot    <= 1'b0;
                    done        <= 1'b1;
                    frame_count <= frame_count + 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_flusher.sv
// tb/tb_frame_flusher.sv - randomized and directed bench for frame_flusher against a frame-timeline model
module tb_frame_flusher;

    localparam int          W    = 4;
    localparam int          H    = 3;
    localparam int          NPIX = W * H;
    localparam logic [5:0]  BG   = 6'h2A;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] layer_colour;
    logic [3:0]  layer_enable;
    logic [7:0]  flush_x, flush_y, vga_x, vga_y, frame_count;
    logic [5:0]  vga_colour;
    logic        vga_plot, busy, done;

    int          mode = 0;
    logic [23:0] rnd_colour = '0;
    logic [3:0]  rnd_en = '0;

    int n_vec = 0;
    int n_err = 0;

    frame_flusher #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .N_LAYERS  (4),
        .BG_COLOUR (BG)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .layer_colour (layer_colour),
        .layer_enable (layer_enable),
        .flush_x      (flush_x),
        .flush_y      (flush_y),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .busy         (busy),
        .done         (done),
        .frame_count  (frame_count)
    );

    always #5 clock = ~clock;

    // Layer stand-ins: mode 1 is the priority pattern keyed on the scan coordinate.
    always_comb begin
        layer_colour = rnd_colour;
        layer_enable = 4'b0000;
        case (mode)
            1: begin
                layer_colour = {6'h15, 6'h01, 6'h0C, 6'h3F};
                layer_enable = {1'b0, 1'b1, 1'b1, (flush_x == 8'd2 && flush_y == 8'd1)};
            end
            2: layer_enable = rnd_en;
            default: layer_enable = 4'b0000;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int prio(input logic [23:0] c, input logic [3:0] e);
        for (int i = 0; i < 4; i++) begin
            if (e[i]) return int'(c[i*6 +: 6]);
        end
        return int'(BG);
    endfunction

    // Model: k counts cycles since a frame was accepted (0 = idle). Cycle k in 1..NPIX scans
    // pixel k-1, cycle k in 2..NPIX+1 shows the plot of pixel k-2, cycle NPIX+2 is the done cycle.
    int   k = 0;
    int   m_fc = 0;
    int   m_x = 0, m_y = 0, m_c = 0;
    bit   armed = 0;

    always @(posedge clock) begin
        if (reset) begin
            k = 0; m_fc = 0; m_x = 0; m_y = 0; m_c = 0;
            armed = 1;
        end else begin
            if (k >= 1 && k <= NPIX) begin
                m_x = (k - 1) % W;
                m_y = (k - 1) / W;
                m_c = prio(layer_colour, layer_enable);
            end
            if (k == NPIX + 1) m_fc = (m_fc + 1) % 256;
            if (k == 0 || k == NPIX + 2) k = start ? 1 : 0;
            else k = k + 1;
        end
    end

    int plots_seen = 0;
    int dones_seen = 0;
    int col21 = -1;
    int n_0c = 0;

    always @(negedge clock) begin
        if (armed) begin
            chk("flush_x",     flush_x,     (k >= 1 && k <= NPIX) ? (k - 1) % W : 0);
            chk("flush_y",     flush_y,     (k >= 1 && k <= NPIX) ? (k - 1) / W : 0);
            chk("vga_plot",    vga_plot,    (k >= 2 && k <= NPIX + 1) ? 1 : 0);
            chk("vga_x",       vga_x,       m_x);
            chk("vga_y",       vga_y,       m_y);
            chk("vga_colour",  vga_colour,  m_c);
            chk("busy",        busy,        (k >= 1 && k <= NPIX + 2) ? 1 : 0);
            chk("done",        done,        (k == NPIX + 2) ? 1 : 0);
            chk("frame_count", frame_count, m_fc);
            if (vga_plot) begin
                plots_seen++;
                if (mode == 1 && vga_x == 8'd2 && vga_y == 8'd1) col21 = int'(vga_colour);
                if (mode == 1 && vga_colour == 6'h0C) n_0c++;
            end
            if (done) dones_seen++;
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 4 * NPIX + 20 && !seen; i++) begin
            step();
            if (done) seen = 1;
        end
        if (!seen) chk({name, "_done_timeout"}, 0, 1);
    endtask

    int base_p, base_d, cnt;

    initial begin
        do_reset();

        // All layers off: twelve background plots, one done, one frame counted
        mode = 0;
        base_p = plots_seen; base_d = dones_seen;
        pulse_start();
        wait_done("bg");
        chk("bg_plots", plots_seen - base_p, 12);
        chk("bg_dones", dones_seen - base_d, 1);
        chk("bg_frame_count", frame_count, 1);
        step(); step();

        // Priority: layer 0 only at (2,1), layer 1 everywhere
        mode = 1;
        n_0c = 0;
        pulse_start();
        wait_done("prio");
        chk("prio_col21", col21, 'h3F);
        chk("prio_n0c", n_0c, 11);
        step();
        mode = 0;
        step();

        // Start pulses during the scan are ignored
        base_p = plots_seen; base_d = dones_seen;
        pulse_start();
        repeat (3) step();
        pulse_start();
        repeat (2) step();
        pulse_start();
        wait_done("ignore");
        repeat (4) step();
        chk("ignore_plots", plots_seen - base_p, 12);
        chk("ignore_dones", dones_seen - base_d, 1);

        // Held start: three chained frames
        do_reset();
        base_p = plots_seen;
        cnt = 0;
        start = 1'b1;
        for (int i = 0; i < 3 * (NPIX + 2) + 20 && cnt < 3; i++) begin
            step();
            if (done) cnt++;
        end
        start = 1'b0;
        chk("held_dones", cnt, 3);
        repeat (3) step();
        chk("held_plots", plots_seen - base_p, 36);
        chk("held_frame_count", frame_count, 3);

        // Reset at the 6th plot cycle
        base_p = plots_seen;
        pulse_start();
        for (int i = 0; i < 20 && (plots_seen - base_p) < 6; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_vga_plot", vga_plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flush_x", flush_x, 0);
        chk("rst_flush_y", flush_y, 0);
        chk("rst_frame_count", frame_count, 0);
        base_p = plots_seen;
        pulse_start();
        wait_done("after_rst");
        chk("after_rst_plots", plots_seen - base_p, 12);
        step();

        // Randomized layers, starts and occasional resets
        mode = 2;
        for (int i = 0; i < 1500; i++) begin
            rnd_colour = 24'($urandom);
            rnd_en     = 4'($urandom);
            start      = ($urandom_range(0, 3) == 0);
            reset      = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (NPIX + 4) step();
        mode = 0;

        // Frame counter wrap over 256 frames
        do_reset();
        cnt = 0;
        start = 1'b1;
        for (int i = 0; i < 256 * (NPIX + 2) + 50 && cnt < 256; i++) begin
            step();
            if (done) begin
                cnt++;
                if (cnt == 255) chk("wrap_fc_255", frame_count, 255);
            end
        end
        start = 1'b0;
        chk("wrap_dones", cnt, 256);
        chk("wrap_fc_0", frame_count, 0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/frame_flusher.md
Name: frame_flusher

Overview:
- Raster-scan controller for the 160x120 game framebuffer.
- Drives flush_x/flush_y to all combinational layer blocks (titles, sprites, HUD). Samples their colour/enable pairs, resolves layer priority, and emits one registered plot per cycle to the VGA adapter.
- Sits between the game FSM, which issues start, and the vga_adapter write port.

Parameters:
- WIDTH, 160, pixels per row; range 1..256.
- HEIGHT, 120, rows per frame; range 1..256.
- N_LAYERS, 4, number of layer colour/enable pairs.
- BG_COLOUR, 6'b000000, colour plotted where no layer is enabled.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a frame when idle.
- layer_colour  in  6*N_LAYERS  layer i colour at bits [6i+5:6i].
- layer_enable  in  N_LAYERS  layer i claims the current pixel.
- flush_x  out  8  current scan column, fed to layers.
- flush_y  out  8  current scan row, fed to layers.
- vga_x  out  8  registered plot column.
- vga_y  out  8  registered plot row.
- vga_colour  out  6  registered plot colour.
- vga_plot  out  1  write strobe to vga_adapter.
- busy  out  1  high from frame accept through the done cycle.
- done  out  1  one-cycle pulse at frame end.
- frame_count  out  8  completed frames; wraps 255->0.

Behaviour:
- Reset (clock edge with reset=1): state IDLE.
  - All outputs 0; vga_colour = 0, not BG_COLOUR.
  - Reset overrides everything, including mid-frame. No plot is issued in the cycle after a reset edge.
- States: IDLE, SCAN, FINISH.
- IDLE:
  - flush_x/flush_y held at 0; vga_plot=0.
  - start=1 at an edge -> SCAN, busy=1.
- SCAN, every cycle:
  - Layers respond combinationally to flush_x/flush_y in the same cycle.
  - Priority encode: lowest index i with layer_enable[i]=1 wins and its colour is selected. If none is enabled, select BG_COLOUR.
  - On the edge: vga_x<=flush_x, vga_y<=flush_y, vga_colour<=selected, vga_plot<=1. Latency from coordinate to plot is 1 cycle.
  - Advance: if flush_x==WIDTH-1, then flush_x<=0 and flush_y<=flush_y+1; otherwise flush_x<=flush_x+1.
  - Last pixel (WIDTH-1, HEIGHT-1): flush_x/flush_y<=0, state -> FINISH.
- FINISH, exactly one cycle:
  - vga_plot holds the last pixel's plot.
  - On the edge: vga_plot<=0, done<=1, busy stays 1, frame_count<=frame_count+1 (mod 256), state -> IDLE.
- Next cycle (IDLE): done<=0, busy<=0.
  - done is visible exactly in the cycle after the last plot cycle.
- Totals per frame: exactly WIDTH*HEIGHT plot cycles, contiguous, with no gaps. Each (x,y) is plotted exactly once, in row-major order.
- start while busy=1 is ignored, not queued. start held high re-triggers from IDLE, giving back-to-back frames with one idle cycle between them.
- vga_x/vga_y/vga_colour hold their last values while vga_plot=0.
- Arithmetic: counters are 8-bit unsigned; no wrap is reachable within legal parameter ranges.

Decomposition:
- Shared package: COLOUR_W=6, COORD_W=8, SCREEN_W=160, SCREEN_H=120, and the state enum {IDLE, SCAN, FINISH}.
- One natural sub-module: layer_priority_mux. It is combinational, maps N_LAYERS colour/enable pairs plus BG_COLOUR to a single colour, and is reusable by other compositors.

Test Plan:
- WIDTH=4, HEIGHT=3, all enables 0, pulse start -> 12 consecutive plot cycles with (x,y) = (0,0),(1,0),(2,0),(3,0),(0,1)..(3,2), all at BG_COLOUR. done pulses once the cycle after the last plot; frame_count=1.
- Layer 0 enabled only at (2,1) with colour 6'h3F, layer 1 enabled everywhere with 6'h0C -> (2,1) plots 6'h3F and every other pixel plots 6'h0C (priority check).
- start pulsed at plot cycles 3 and 7 of a frame -> ignored; exactly 12 plots and one done.
- start held high for 3 frames -> 3 done pulses, 36 plots, exactly one idle cycle between frames, frame_count=3.
- reset asserted at the 6th plot cycle -> next cycle vga_plot=0, busy=0, flush=(0,0), frame_count=0. A following start produces a clean full frame.
- frame_count driven through 256 frames (short parameters) -> wraps 255->0 on the 256th done.
